// File: rtl/root_mul_if.sv
`timescale 1ns/1ps
// root_mul_if: start/busy/done handshake and operand/result bus of root_mul.
// The controller drives through the master modport; root_mul uses the slave modport.
interface root_mul_if #(
    parameter int A_W = 8,
    parameter int B_W = 8
);
    localparam int RES_W = A_W + (B_W + 32'sd1) / 32'sd2;

    logic             start;
    logic             mode_i;
    logic [A_W-1:0]   a_i;
    logic [B_W-1:0]   b_i;
    logic [RES_W-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, mode_i, a_i, b_i,
        input  result, busy, done
    );

    modport slave (
        input  start, mode_i, a_i, b_i,
        output result, busy, done
    );
endinterface

// File: rtl/root_mul.sv
`timescale 1ns/1ps
// root_mul: iterative result = a * floor(root(b)); cube root (mode 0) or square root (mode 1).
// The root is extracted one digit per cycle (restoring method), then multiplied
// by shift-add over the latched a, LSB first.
// Optional build macro ROOT_MUL_EARLY_EXIT_EN: the multiply phase stops as soon as
// the remaining multiplier bits are all zero (minimum one cycle); results are unchanged.
module root_mul #(
    parameter int A_W = 8,
    parameter int B_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    root_mul_if.slave bus
);
    localparam int RES_W = A_W + (B_W + 32'sd1) / 32'sd2;
    localparam int CB_IT = (B_W + 32'sd2) / 32'sd3;
    localparam int SQ_IT = (B_W + 32'sd1) / 32'sd2;
    // Root width: the square root is the wider of the two roots.
    localparam int YW    = SQ_IT;
    // Trial value width: holds 3*y'*(y'+1)+1 for the widest y' without truncation.
    localparam int TW    = B_W + 32'sd2 * YW + 32'sd4;
    localparam int CW    = $clog2(SQ_IT + 32'sd1);
    localparam int KW    = $clog2(A_W + 32'sd1);

    localparam logic [CW-1:0] CB_LAST = CW'(CB_IT - 32'sd1);
    localparam logic [CW-1:0] SQ_LAST = CW'(SQ_IT - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [KW-1:0] K_LAST  = KW'(A_W - 32'sd1);
    localparam logic [KW-1:0] K_ONE   = KW'(1'b1);
    localparam logic [TW-1:0] T_ONE   = TW'(1'b1);
    localparam logic [TW-1:0] T_THREE = TW'(2'b11);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROOT = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [A_W-1:0]   m_q, m_d;
    logic [B_W-1:0]   x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic [RES_W-1:0] ysh_q, ysh_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [TW-1:0]    y2_s;
    logic [TW-1:0]    t_cube_s;
    logic [TW-1:0]    t_sq_s;
    logic [TW-1:0]    t_s;
    logic [31:0]      cnt32_s;
    logic [31:0]      sh_s;
    logic             take_s;
    logic [RES_W-1:0] add_s;
    logic             last_mul_s;

    // Next-state logic for the IDLE -> ROOT -> MUL sequence and the datapath registers.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        m_d      = m_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        ysh_d    = ysh_q;
        acc_d    = acc_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // Trial value for the current digit; s = 3*cnt (cube) or 2*cnt (square).
        y2_s     = TW'(y_q) << 1;
        t_cube_s = T_THREE * y2_s * (y2_s + T_ONE) + T_ONE;
        t_sq_s   = (y2_s << 1) + T_ONE;
        t_s      = mode_q ? t_sq_s : t_cube_s;
        cnt32_s  = 32'(cnt_q);
        sh_s     = mode_q ? (cnt32_s + cnt32_s) : (cnt32_s + cnt32_s + cnt32_s);
        take_s   = ((TW'(x_q) >> sh_s) >= t_s);
        add_s    = m_q[0] ? ysh_q : {RES_W{1'b0}};
`ifdef ROOT_MUL_EARLY_EXIT_EN
        last_mul_s = ((m_q >> 1) == {A_W{1'b0}}) || (k_q == K_LAST);
`else
        last_mul_s = (k_q == K_LAST);
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode_i;
                    m_d     = bus.a_i;
                    x_d     = bus.b_i;
                    y_d     = {YW{1'b0}};
                    acc_d   = {RES_W{1'b0}};
                    k_d     = {KW{1'b0}};
                    cnt_d   = bus.mode_i ? SQ_LAST : CB_LAST;
                    busy_d  = 1'b1;
                    state_d = S_ROOT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROOT: begin
                if (take_s) begin
                    x_d = x_q - B_W'(t_s << sh_s);
                end else begin
                    x_d = x_q;
                end
                // y <= 2y + digit; the root never outgrows YW bits.
                y_d = YW'({y_q, take_s});
                if (cnt_q == {CW{1'b0}}) begin
                    ysh_d   = RES_W'(y_d);
                    acc_d   = {RES_W{1'b0}};
                    k_d     = {KW{1'b0}};
                    state_d = S_MUL;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_MUL: begin
                acc_d = acc_q + add_s;
                m_d   = m_q >> 1;
                ysh_d = ysh_q << 1;
                k_d   = k_q + K_ONE;
                if (last_mul_s) begin
                    result_d = acc_d;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_MUL;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            m_q      <= {A_W{1'b0}};
            x_q      <= {B_W{1'b0}};
            y_q      <= {YW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            k_q      <= {KW{1'b0}};
            ysh_q    <= {RES_W{1'b0}};
            acc_q    <= {RES_W{1'b0}};
            result_q <= {RES_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            m_q      <= m_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            ysh_q    <= ysh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_root_mul.sv
`timescale 1ns/1ps
// tb_root_mul: scoreboard bench for root_mul; a default 8/8 instance and a 4/12 instance.
// Honours ROOT_MUL_EARLY_EXIT_EN when predicting busy length.
module tb_root_mul;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    root_mul_if #(.A_W(8), .B_W(8))  bus0 ();
    root_mul_if #(.A_W(4), .B_W(12)) bus1 ();

    root_mul #(.A_W(8), .B_W(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    root_mul #(.A_W(4), .B_W(12)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   bc0   = 0;
    int   bc1   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference root by plain search: largest r with r^k <= b.
    function automatic logic [63:0] root_of(bit m, logic [63:0] b);
        logic [63:0] r = 64'd0;
        if (m) begin
            while ((r + 64'd1) * (r + 64'd1) <= b) r++;
        end else begin
            while ((r + 64'd1) * (r + 64'd1) * (r + 64'd1) <= b) r++;
        end
        return r;
    endfunction

    // Expected busy cycles: root digits plus multiply cycles.
    function automatic int lat_of(bit m, logic [63:0] a, int aw, int bw);
        int it = m ? (bw + 1) / 2 : (bw + 2) / 3;
        int mc = aw;
`ifdef ROOT_MUL_EARLY_EXIT_EN
        mc = 1;
        for (int i = 0; i < aw; i++) if (a[i]) mc = i + 1;
`endif
        return it + mc;
    endfunction

    function automatic exp_t model(bit which, bit m, logic [15:0] a, logic [15:0] b);
        exp_t e;
        e.res = 64'(a) * root_of(m, 64'(b));
        e.lat = lat_of(m, 64'(a), which ? 4 : 8, which ? 12 : 8);
        return e;
    endfunction

    task automatic score(bit which, logic busy, logic [63:0] res, int lat);
        exp_t e;
        check(which ? "done_busy_low_1" : "done_busy_low_0", {63'd0, busy}, 64'd0);
        if ((which ? q1.size() : q0.size()) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done_%0d: got done with result %0d, required no done", which, res);
        end else begin
            e = which ? q1.pop_front() : q0.pop_front();
            check(which ? "result_1" : "result_0", res, e.res);
            check(which ? "busy_cycles_1" : "busy_cycles_0", 64'(lat), 64'(e.lat));
        end
    endtask

    // Monitor for the default instance: counts busy cycles, scores each done pulse.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            bc0 = 0;
        end else begin
            if (bus0.busy === 1'b1) bc0++;
            if (bus0.done === 1'b1) begin
                score(1'b0, bus0.busy, 64'(bus0.result), bc0);
                bc0 = 0;
            end
        end
    end

    // Monitor for the 4/12 instance.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            bc1 = 0;
        end else begin
            if (bus1.busy === 1'b1) bc1++;
            if (bus1.done === 1'b1) begin
                score(1'b1, bus1.busy, 64'(bus1.result), bc1);
                bc1 = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(bit which);
        int g = 0;
        while ((which ? bus1.busy : bus0.busy) !== 1'b0 && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout_%0d: busy still high after %0d cycles, required low", which, g);
        end
    endtask

    task automatic wait_drain(bit which);
        int g = 0;
        while ((which ? q1.size() : q0.size()) != 0 && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout_%0d: %0d ops pending, required 0", which,
                     which ? q1.size() : q0.size());
            if (which) q1.delete(); else q0.delete();
        end
    endtask

    // Present one operation at an idle cycle; it is accepted on the next edge.
    task automatic issue(bit which, bit m, logic [15:0] a, logic [15:0] b);
        exp_t e;
        wait_idle(which);
        e = model(which, m, a, b);
        if (which) begin
            bus1.mode_i = m; bus1.a_i = a[3:0]; bus1.b_i = b[11:0]; bus1.start = 1'b1;
            q1.push_back(e);
        end else begin
            bus0.mode_i = m; bus0.a_i = a[7:0]; bus0.b_i = b[7:0]; bus0.start = 1'b1;
            q0.push_back(e);
        end
        step();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic run(bit which, bit m, logic [15:0] a, logic [15:0] b);
        issue(which, m, a, b);
        wait_drain(which);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b0;
        bus0.start = 1'b0; bus0.mode_i = 1'b0; bus0.a_i = 8'd0; bus0.b_i = 8'd0;
        bus1.start = 1'b0; bus1.mode_i = 1'b0; bus1.a_i = 4'd0; bus1.b_i = 12'd0;
        repeat (3) step();
        check("reset_busy_0", 64'(bus0.busy), 64'd0);
        check("reset_done_0", 64'(bus0.done), 64'd0);
        check("reset_result_0", 64'(bus0.result), 64'd0);
        check("reset_busy_1", 64'(bus1.busy), 64'd0);
        check("reset_result_1", 64'(bus1.result), 64'd0);
        rst = 1'b1;
        step();

        // Directed cube and square cases, including zero operands.
        run(1'b0, 1'b0, 16'd5, 16'd27);
        run(1'b0, 1'b0, 16'd9, 16'd125);
        run(1'b0, 1'b0, 16'd255, 16'd255);
        run(1'b0, 1'b1, 16'd7, 16'd200);
        run(1'b0, 1'b1, 16'd255, 16'd255);
        run(1'b0, 1'b1, 16'd3, 16'd0);
        run(1'b0, 1'b0, 16'd0, 16'd27);
        run(1'b0, 1'b0, 16'd128, 16'd8);

        // Start and operand changes while busy are ignored.
        issue(1'b0, 1'b0, 16'd5, 16'd27);
        step();
        bus0.start = 1'b1; bus0.mode_i = 1'b1; bus0.a_i = 8'd1; bus0.b_i = 8'd8;
        step();
        bus0.start = 1'b0; bus0.a_i = 8'd77; bus0.b_i = 8'd99;
        wait_drain(1'b0);
        repeat (15) step();
        check("no_second_op_busy", 64'(bus0.busy), 64'd0);
        check("no_second_op_result", 64'(bus0.result), 64'd15);

        // Reset in busy cycle 4 aborts the operation silently.
        issue(1'b0, 1'b0, 16'd9, 16'd125);
        step();
        step();
        rst = 1'b0;
        step();
        check("abort_busy", 64'(bus0.busy), 64'd0);
        check("abort_done", 64'(bus0.done), 64'd0);
        check("abort_result", 64'(bus0.result), 64'd0);
        q0.delete();
        rst = 1'b1;
        repeat (15) step();
        check("abort_no_done_late", 64'(bus0.result), 64'd0);
        run(1'b0, 1'b0, 16'd3, 16'd64);

        // start held high: a new op begins each time IDLE is reached.
        bus0.mode_i = 1'b1; bus0.a_i = 8'd200; bus0.b_i = 8'd150; bus0.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_idle(1'b0);
            e = model(1'b0, 1'b1, 16'd200, 16'd150);
            q0.push_back(e);
            step();
        end
        bus0.start = 1'b0;
        wait_drain(1'b0);

        // Parametrised instance, extremes.
        run(1'b1, 1'b0, 16'd15, 16'd4095);
        run(1'b1, 1'b1, 16'd15, 16'd4095);
        run(1'b1, 1'b1, 16'd0, 16'd4095);

        // Randomized traffic on both instances.
        for (int i = 0; i < 30; i++) begin
            run(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 15; i++) begin
            run(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom_range(0, 4095)));
        end

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/root_mul.md
Name: root_mul

Overview:
- Iterative sequential arithmetic unit; next generation of the team's `fun` multiply-by-cube-root block.
- Computes result = a × floor(root(b)).
- Root is cube root (mode 0) or square root (mode 1), selected per operation.
- Operand widths are parametrised; start/busy handshake is kept; a one-cycle done pulse is added.
- Sits as a leaf compute block under a controller that pulses start and waits for busy to fall.

Parameters:
- A_W, 8: width of multiplicand a_i.
- B_W, 8: width of radicand b_i.
- Derived, not overridable:
  - RES_W = A_W + (B_W+1)/2
  - CB_IT = (B_W+2)/3
  - SQ_IT = (B_W+1)/2

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-low reset; sampled on rising edge of clk, active when 0.
- start  in  1  operation request; accepted only in IDLE.
- mode_i  in  1  0 = cube root, 1 = square root.
- a_i  in  A_W  unsigned multiplicand.
- b_i  in  B_W  unsigned radicand.
- result  out  RES_W  unsigned product; held until next completion or reset.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; busy=0, done=0, result=0; internal registers cleared.
  - Reset has priority over every other event, including mid-operation. The aborted op produces no done pulse and no result update.
- States: IDLE, ROOT, MUL.
- IDLE:
  - On an edge with start=1, latch a_i, b_i, mode_i.
  - Clear root y, remainder x=b, accumulator.
  - busy<=1, state<=ROOT. done<=0 in every IDLE cycle unless set on completion.
- ROOT, cube (mode 0): CB_IT cycles, one digit per cycle, shift s from 3·(CB_IT−1) down to 0 in steps of 3:
  - y<=2y; t=3y'(y'+1)+1 with y'=2y.
  - If (x>>s)≥t then x<=x−(t<<s) and y<=y'+1.
- ROOT, square (mode 1): SQ_IT cycles, s from 2·(SQ_IT−1) down to 0 in steps of 2:
  - y'=2y; t=2y'+1 (i.e. 4y+1).
  - If (x>>s)≥t then x<=x−(t<<s) and y<=y'+1, else y<=y'.
- After the last ROOT cycle, y=floor(root(b)), width ≤ (B_W+1)/2 bits; state<=MUL. Intermediate t is computed at full width with no truncation.
- MUL: shift-add over the latched a, LSB first, A_W cycles.
  - Each cycle: if m[0], acc<=acc+(y<<k); m<=m>>1; k<=k+1.
  - On the last MUL edge: result<=final acc, busy<=0, done<=1 for exactly one cycle, state<=IDLE.
- Latency:
  - busy is high for CB_IT+A_W cycles (mode 0) or SQ_IT+A_W cycles (mode 1).
  - Defaults: 11 cycles (mode 0) and 12 cycles (mode 1).
  - A new start is accepted on the edge after done is asserted (done cycle is IDLE).
- Boundaries:
  - start while busy: ignored.
  - Operand or mode changes while busy: ignored; latched values are used.
  - b=0 or a=0: result=0 with normal latency.
  - Max operands never overflow RES_W.
  - start held high continuously: a new op starts each time IDLE is reached.

Optional Feature:
- Macro: ROOT_MUL_EARLY_EXIT_EN.
- Defined: MUL terminates on the edge where the updated m becomes 0, minimum 1 cycle. MUL cycles = max(1, index of highest set bit of a + 1). Result values are unchanged; only busy length shrinks.
- Undefined: MUL is always exactly A_W cycles.

Test Plan:
1. Defaults, mode 0; a=5, b=27; then a=9, b=125; then a=255, b=255 → results 15, 45, 1530. busy exactly 11 cycles each (early exit off). done one cycle, coincident with busy falling.
2. Mode 1; a=7, b=200 → 98; a=255, b=255 → 3825; a=3, b=0 → 0. busy 12 cycles each.
3. Mid-op: start a=5, b=27 mode 0; at busy cycle 3, pulse start with a=1, b=8, mode 1 and change a_i/b_i → final result 15, no second operation.
4. Reset mid-op: rst=0 during busy cycle 4 → next edge busy=0, result=0, no done. Then a=3, b=64 mode 0 → 12.
5. Parametrised instance A_W=4, B_W=12, mode 0; a=15, b=4095 → 225, busy 8 cycles. Mode 1, a=15, b=4095 → 945, busy 10 cycles.
6. With ROOT_MUL_EARLY_EXIT_EN, defaults, mode 0:
   - a=5, b=27 → 15, busy 3+3=6 cycles.
   - a=0, b=27 → 0, busy 4 cycles.
   - a=128, b=8 → 256, busy 11 cycles.
